fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_match.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 79 +++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Entries carry register addresses at a fixed maximum width; narrower designs zero-extend.
package fwd_pkg;

    localparam int FWD_RF     = 0;
    localparam int REG_AW_MAX = 16;

    typedef logic [REG_AW_MAX-1:0] fwd_reg_t;

    typedef struct packed {
        logic     valid;
        logic     wr;
        fwd_reg_t rd;
        logic     swap;
        fwd_reg_t rd2;
        logic     load;
    } fwd_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority comparator for one source operand: youngest matching stage wins.
// Primary destination beats the secondary one within the same entry.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SELW  = 2
) (
    input  fwd_entry_t [DEPTH-1:0] entries,
    input  logic                   src_valid,
    input  fwd_reg_t               src_reg,
    output logic [SELW-1:0]        sel,
    output logic                   alt,
    output logic                   load_use
);

    always_comb begin
        sel = SELW'(FWD_RF);
        alt = 1'b0;
        // Walk oldest to youngest so the youngest hit is the last one written.
        for (int k = DEPTH; k >= 1; k--) begin
            logic prim;
            logic sec;
            prim = entries[k-1].valid && entries[k-1].wr   && (entries[k-1].rd  == src_reg);
            sec  = entries[k-1].valid && entries[k-1].swap && (entries[k-1].rd2 == src_reg);
            if (src_valid && (prim || sec)) begin
                sel = SELW'(k);
                alt = !prim;
            end
        end
        load_use = src_valid && (sel == SELW'(1)) && entries[0].load;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations and produces per-operand bypass selects and a load-use stall.
// Entry index k-1 holds pipeline stage k.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int REG_AW  = 4,
    parameter  int NUM_SRC = 2,
    parameter  int DEPTH   = 2,
    localparam int SELW    = sel_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      issue_swap,
    input  logic [REG_AW-1:0]         issue_rd2,
    input  logic                      issue_load,
    input  logic                      hold,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [NUM_SRC-1:0]        fwd_alt,
    output logic                      stall,
    output logic [SELW-1:0]           inflight
);

    fwd_entry_t [DEPTH-1:0] entries;
    fwd_entry_t             issue_entry;
    logic [NUM_SRC-1:0]     load_use;

    always_comb begin
        issue_entry.valid = issue_valid;
        issue_entry.wr    = issue_wr;
        issue_entry.rd    = REG_AW_MAX'(issue_rd);
        issue_entry.swap  = issue_swap;
        issue_entry.rd2   = REG_AW_MAX'(issue_rd2);
        issue_entry.load  = issue_load;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_reg_t src_ext;
        assign src_ext = REG_AW_MAX'(src_reg[i*REG_AW +: REG_AW]);

        fwd_match #(
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_match (
            .entries   (entries),
            .src_valid (src_valid[i]),
            .src_reg   (src_ext),
            .sel       (fwd_sel[i*SELW +: SELW]),
            .alt       (fwd_alt[i]),
            .load_use  (load_use[i])
        );
    end

    assign stall = |load_use;

    // Hold freezes everything, so a pending stall simply persists until the pipe moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[0] <= stall ? '0 : issue_entry;
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight = inflight + SELW'(entries[k].valid);
        end
    end

endmodule
